// File: rtl/xor_link_pkg.sv
// Shared definitions for the XOR nibble link: keystream LFSR geometry,
// default seed, nibble width and the receive-side state encoding.
package xor_link_pkg;

  localparam int LFSR_W   = 8;
  localparam int NIBBLE_W = 4;

  // Feedback taps of the Fibonacci keystream generator.
  localparam int TAP_A = 7;
  localparam int TAP_B = 5;
  localparam int TAP_C = 4;
  localparam int TAP_D = 3;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2
  } link_state_e;

  // One keystream step; the scrambler uses the same function so both link
  // ends stay in lock-step.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], cur[TAP_A] ^ cur[TAP_B] ^ cur[TAP_C] ^ cur[TAP_D]};
  endfunction

endpackage

// File: rtl/xor_lfsr8.sv
// Keystream register shared by both link ends. A load restarts the sequence
// from 'seed'; load together with advance yields next(seed) in one cycle,
// which is what a start-of-frame beat needs.
module xor_lfsr8
  import xor_link_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_VAL = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] value_q;
  logic [LFSR_W-1:0] value_d;
  logic [LFSR_W-1:0] base;

  // Select restart point, then optionally step once.
  always_comb begin
    base    = load ? seed : value_q;
    value_d = advance ? lfsr_next(base) : base;
  end

  // Keystream state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= RESET_VAL;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/xor_descrambler.sv
// Receive-side XOR nibble descrambler with per-frame parity check.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a start-of-frame beat; non-SOF beats dropped
//   ST_DATA  | descrambling data nibbles into the output register
//   ST_CHECK | waiting for the trailing check nibble (no output produced)
//
// An SOF beat in any state starts a fresh frame; if a frame was in flight
// it is abandoned silently apart from a sync_err pulse.
module xor_descrambler
  import xor_link_pkg::*;
#(
  parameter int                FRAME_NIBBLES = 8,
  parameter logic [LFSR_W-1:0] SEED          = DEFAULT_SEED
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NIBBLE_W-1:0] in_data,
  input  logic                in_sof,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NIBBLE_W-1:0] out_data,
  output logic                out_last,
  output logic                frame_done,
  output logic                frame_ok,
  output logic                sync_err
);

  localparam int CNT_W = (FRAME_NIBBLES > 2) ? $clog2(FRAME_NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_DATA_CNT = CNT_W'(FRAME_NIBBLES - 2);
  localparam bit SHORT_FRAME = (FRAME_NIBBLES == 2);

  if (FRAME_NIBBLES < 2) begin : g_bad_len
    $error("xor_descrambler: FRAME_NIBBLES must be at least 2");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("xor_descrambler: SEED must be nonzero");
  end

  link_state_e         state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [NIBBLE_W-1:0] parity_q, parity_d;
  logic                out_valid_q, out_valid_d;
  logic [NIBBLE_W-1:0] out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_ok_q, frame_ok_d;
  logic                sync_err_q, sync_err_d;

  logic                lfsr_load;
  logic                lfsr_adv;
  logic [LFSR_W-1:0]   lfsr_value;
  logic                unused_lfsr_hi;

  logic                accept;
  logic [NIBBLE_W-1:0] key;
  logic [NIBBLE_W-1:0] plain;

  xor_lfsr8 #(
    .RESET_VAL (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .seed    (SEED),
    .value   (lfsr_value)
  );

  // Only the low nibble of the keystream is used as key material.
  assign unused_lfsr_hi = ^lfsr_value[LFSR_W-1:NIBBLE_W];

  // Backpressure: only data beats need room in the output register.
  always_comb begin
    in_ready = 1'b1;
    case (state_q)
      ST_DATA: in_ready = ~out_valid_q | out_ready;
      default: in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid & in_ready;

  // An SOF beat always uses the seed key, whatever the register holds.
  always_comb begin
    key   = in_sof ? SEED[NIBBLE_W-1:0] : lfsr_value[NIBBLE_W-1:0];
    plain = in_data ^ key;
  end

  // Next-state, keystream control and output register update.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    parity_d     = parity_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    sync_err_d   = 1'b0;
    lfsr_load    = 1'b0;
    lfsr_adv     = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (in_sof) begin
        if (state_q != ST_IDLE) begin
          sync_err_d = 1'b1;
        end
        lfsr_load   = 1'b1;
        lfsr_adv    = 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = plain;
        parity_d    = plain;
        count_d     = CNT_W'(1);
        if (SHORT_FRAME) begin
          out_last_d = 1'b1;
          state_d    = ST_CHECK;
        end else begin
          out_last_d = 1'b0;
          state_d    = ST_DATA;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            sync_err_d = 1'b1;
          end
          ST_DATA: begin
            lfsr_adv    = 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = plain;
            parity_d    = parity_q ^ plain;
            count_d     = count_q + CNT_W'(1);
            if (count_q == LAST_DATA_CNT) begin
              out_last_d = 1'b1;
              state_d    = ST_CHECK;
            end else begin
              out_last_d = 1'b0;
            end
          end
          ST_CHECK: begin
            lfsr_adv     = 1'b1;
            frame_done_d = 1'b1;
            frame_ok_d   = (parity_q == plain);
            count_d      = '0;
            parity_d     = '0;
            state_d      = ST_IDLE;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      parity_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      parity_q     <= parity_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_xor_descrambler.sv
// Bench for xor_descrambler: directed frames from the test plan followed by
// randomized traffic, all checked against a beat-level reference model.
module tb_xor_descrambler;

  localparam int         N      = 4;
  localparam logic [7:0] SEED_V = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_sof;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;
  logic       frame_done;
  logic       frame_ok;
  logic       sync_err;

  xor_descrambler #(
    .FRAME_NIBBLES (N),
    .SEED          (SEED_V)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sof     (in_sof),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Keystream nibble for each beat position of a frame.
  logic [3:0] keys [N];

  function automatic void build_keys();
    logic [7:0] s;
    s = SEED_V;
    for (int i = 0; i < N; i++) begin
      keys[i] = s[3:0];
      s = {s[6:0], ^(s & 8'hB8)};
    end
  endfunction

  // Reference model: position inside the current frame plus the output
  // register contents and pulse flags as seen after each clock edge.
  bit         m_in_frame;
  int         m_pos;
  logic [3:0] m_parity;
  bit         m_ov;
  logic [3:0] m_od;
  bit         m_ol;
  bit         m_fd;
  bit         m_fok;
  bit         m_se;

  logic [3:0] out_log [$];
  bit         last_log [$];
  int         done_cnt;
  bit         last_ok;
  int         serr_cnt;

  task automatic model_reset();
    m_in_frame = 0; m_pos = 0; m_parity = '0;
    m_ov = 0; m_od = '0; m_ol = 0;
    m_fd = 0; m_fok = 0; m_se = 0;
  endtask

  task automatic step(input bit v, input bit sof, input logic [3:0] d, input bit ordy, output bit acc);
    bit         exp_rdy;
    logic [3:0] plain;
    @(negedge clk);
    check_val("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      check_val("out_data", 32'(out_data), 32'(m_od));
      check_val("out_last", 32'(out_last), 32'(m_ol));
    end
    check_val("frame_done", 32'(frame_done), 32'(m_fd));
    check_val("frame_ok", 32'(frame_ok), 32'(m_fok));
    check_val("sync_err", 32'(sync_err), 32'(m_se));
    if (frame_done) begin
      done_cnt++;
      last_ok = frame_ok;
    end
    if (sync_err) serr_cnt++;

    in_valid  = v;
    in_sof    = sof;
    in_data   = d;
    out_ready = ordy;
    #1;
    exp_rdy = !m_in_frame || (m_pos == N - 1) || !m_ov || ordy;
    check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (out_valid && ordy) begin
      out_log.push_back(out_data);
      last_log.push_back(out_last);
    end
    acc = v && exp_rdy;

    m_fd = 0;
    m_se = 0;
    if (m_ov && ordy) m_ov = 0;
    if (acc) begin
      if (sof) begin
        if (m_in_frame) m_se = 1;
        plain      = d ^ keys[0];
        m_in_frame = 1;
        m_pos      = 1;
        m_parity   = plain;
        m_ov       = 1;
        m_od       = plain;
        m_ol       = (N == 2);
      end else if (!m_in_frame) begin
        m_se = 1;
      end else begin
        plain = d ^ keys[m_pos];
        if (m_pos == N - 1) begin
          m_fd       = 1;
          m_fok      = (m_parity == plain);
          m_in_frame = 0;
          m_pos      = 0;
        end else begin
          m_ov     = 1;
          m_od     = plain;
          m_ol     = (m_pos == N - 2);
          m_parity = m_parity ^ plain;
          m_pos++;
        end
      end
    end
  endtask

  task automatic send(input bit sof, input logic [3:0] d, input bit rand_rdy, input bit rand_gap);
    bit acc;
    int n;
    bit v;
    bit r;
    acc = 0;
    n   = 0;
    while (!acc && n < 50) begin
      v = rand_gap ? ($urandom_range(0, 3) != 0) : 1'b1;
      r = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      step(v, sof, d, r, acc);
      n++;
    end
    check_val("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n, input bit rand_rdy);
    bit acc;
    for (int i = 0; i < n; i++) begin
      step(0, 0, 4'h0, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, acc);
    end
  endtask

  task automatic clear_logs();
    out_log.delete();
    last_log.delete();
    done_cnt = 0;
    serr_cnt = 0;
    last_ok  = 0;
  endtask

  // Compare the collected outputs of a directed test, then clear them.
  // Entry i of the expected stream sits in ed[4i+3:4i] / el[i].
  task automatic check_log(input string tag, input int n, input logic [31:0] ed, input logic [7:0] el,
                           input int ndone, input bit ok, input int nserr);
    check_val({tag, "_len"}, 32'(out_log.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < out_log.size()) begin
        check_val($sformatf("%s_d%0d", tag, i), 32'(out_log[i]), 32'(ed[4*i +: 4]));
        check_val($sformatf("%s_l%0d", tag, i), 32'(last_log[i]), 32'(el[i]));
      end
    end
    check_val({tag, "_done"}, 32'(done_cnt), 32'(ndone));
    if (ndone > 0) check_val({tag, "_ok"}, 32'(last_ok), 32'(ok));
    check_val({tag, "_serr"}, 32'(serr_cnt), 32'(nserr));
    clear_logs();
  endtask

  task automatic good_frame();
    send(1, 4'h6, 0, 0);
    send(0, 4'h6, 0, 0);
    send(0, 4'h3, 0, 0);
    send(0, 4'h3, 0, 0);
    idle(3, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         acc;
    int         abort_at;
    logic [3:0] par;
    logic [3:0] p;

    build_keys();
    model_reset();
    clear_logs();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b1;

    #12;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_data", 32'(out_data), 32'd0);
    check_val("rst_out_last", 32'(out_last), 32'd0);
    check_val("rst_frame_done", 32'(frame_done), 32'd0);
    check_val("rst_frame_ok", 32'(frame_ok), 32'd0);
    check_val("rst_sync_err", 32'(sync_err), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 0);

    // Clean frame: 6,6,3,3 -> 3,C,6 and good parity.
    good_frame();
    check_log("t1", 3, 32'h6C3, 8'b100, 1, 1, 0);

    // Corrupted check nibble.
    send(1, 4'h6, 0, 0);
    send(0, 4'h6, 0, 0);
    send(0, 4'h3, 0, 0);
    send(0, 4'h2, 0, 0);
    idle(3, 0);
    check_log("t2", 3, 32'h6C3, 8'b100, 1, 0, 0);

    // Stray non-SOF beat while idle, then a normal frame.
    send(0, 4'h7, 0, 0);
    idle(2, 0);
    check_log("t3a", 0, 32'h0, 8'h0, 0, 0, 1);
    good_frame();
    check_log("t3b", 3, 32'h6C3, 8'b100, 1, 1, 0);

    // Downstream stall after the first output.
    send(1, 4'h6, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 4'h6, 0, acc);
      check_val("bp_in_ready", 32'(in_ready), 32'd0);
      check_val("bp_hold_data", 32'(out_data), 32'h3);
    end
    send(0, 4'h6, 0, 0);
    send(0, 4'h3, 0, 0);
    send(0, 4'h3, 0, 0);
    idle(3, 0);
    check_log("t4", 3, 32'h6C3, 8'b100, 1, 1, 0);

    // SOF on the third beat restarts the frame.
    send(1, 4'h6, 0, 0);
    send(0, 4'h6, 0, 0);
    send(1, 4'h6, 0, 0);
    send(0, 4'h6, 0, 0);
    send(0, 4'h3, 0, 0);
    send(0, 4'h3, 0, 0);
    idle(3, 0);
    check_log("t5", 5, 32'h6C3C3, 8'b10000, 1, 1, 1);

    // Asynchronous reset in the middle of a frame.
    send(1, 4'h6, 0, 0);
    send(0, 4'h6, 0, 0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_out_valid", 32'(out_valid), 32'd0);
    check_val("arst_out_data", 32'(out_data), 32'd0);
    check_val("arst_out_last", 32'(out_last), 32'd0);
    check_val("arst_frame_ok", 32'(frame_ok), 32'd0);
    check_val("arst_frame_done", 32'(frame_done), 32'd0);
    check_val("arst_sync_err", 32'(sync_err), 32'd0);
    model_reset();
    clear_logs();
    @(negedge clk);
    rst_n = 1'b1;
    good_frame();
    check_log("t6", 3, 32'h6C3, 8'b100, 1, 1, 0);

    // Randomized traffic with gaps, backpressure, strays, aborts, bad checks.
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 9) == 0) send(0, 4'($urandom), 1, 1);
      abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, N - 1)) : N;
      par = '0;
      for (int i = 0; i < N; i++) begin
        if (i == abort_at) break;
        if (i < N - 1) begin
          p   = 4'($urandom);
          par = par ^ p;
          send(i == 0, p ^ keys[i], 1, 1);
        end else if ($urandom_range(0, 3) != 0) begin
          send(0, par ^ keys[N - 1], 1, 1);
        end else begin
          send(0, 4'($urandom), 1, 1);
        end
      end
      idle(int'($urandom_range(0, 2)), 1);
    end
    idle(5, 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
